// File: rtl/tv_recorder_pkg.sv
// -----------------------------------------------------------------------------
// tv_recorder_pkg
// Shared types, default geometry and helpers for the test-vector recorder.
//   rec_state_t : recorder FSM state encoding (IDLE / RECORD / DRAIN)
//   TV_*        : default widths and buffer depth
//   sat_inc16   : 16-bit saturating increment
// -----------------------------------------------------------------------------
package tv_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_DRAIN  = 2'd2
  } rec_state_t;

  localparam int TV_IN_W  = 3;
  localparam int TV_OUT_W = 1;
  localparam int TV_DEPTH = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/tv_recorder_if.sv
// -----------------------------------------------------------------------------
// tv_recorder_if
// Valid/ready read stream carrying captured records out of the recorder.
//   rd_valid : record available on rd_data
//   rd_ready : sink accepts record
//   rd_data  : record {dut_in, dut_out}
//   rd_last  : rd_data is the final record of the run
// master = recorder side, slave = sink side.
// -----------------------------------------------------------------------------
interface tv_recorder_if #(
  parameter int REC_W = 4
);
  logic             rd_valid;
  logic             rd_ready;
  logic [REC_W-1:0] rd_data;
  logic             rd_last;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/tv_buffer.sv
// -----------------------------------------------------------------------------
// tv_buffer
// DEPTH x REC_W register array, one synchronous write port and one
// asynchronous (zero-latency) read port. Storage is not reset: a run only
// ever reads entries it wrote itself.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// -----------------------------------------------------------------------------
module tv_buffer #(
  parameter int DEPTH = 16,
  parameter int REC_W = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [REC_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [REC_W-1:0]         rdata
);

  logic [REC_W-1:0] mem_r [DEPTH];

  // Record storage write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Zero-latency read.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/tv_recorder.sv
// -----------------------------------------------------------------------------
// tv_recorder
// Captures {dut_in, dut_out} on each sample_en while recording, buffers up to
// DEPTH records, then streams them out over a valid/ready port.
//   clk, reset_n     : clock, asynchronous active-low reset
//   start / stop     : arm capture (IDLE only) / end capture (RECORD only)
//   sample_en        : capture {dut_in, dut_out} this cycle
//   dut_in, dut_out  : captured DUT stimulus / response
//   rd (master)      : record stream, rd_last flags the final record
//   busy             : FSM not in IDLE
//   count            : records captured in the current/last run
//   overflow         : sticky, sample_en while full or while draining
// Optional feature (macro TV_RECORDER_CHECK_EN): adds exp_out input and a
// saturating 16-bit err_count of samples where dut_out != exp_out.
// -----------------------------------------------------------------------------
module tv_recorder
  import tv_recorder_pkg::*;
#(
  parameter int IN_W  = TV_IN_W,
  parameter int OUT_W = TV_OUT_W,
  parameter int DEPTH = TV_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       sample_en,
  input  logic [IN_W-1:0]            dut_in,
  input  logic [OUT_W-1:0]           dut_out,
`ifdef TV_RECORDER_CHECK_EN
  input  logic [OUT_W-1:0]           exp_out,
  output logic [15:0]                err_count,
`endif
  tv_recorder_if.master              rd,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int REC_W = IN_W + OUT_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_RECORD = ST_RECORD;
  localparam logic [1:0] S_DRAIN  = ST_DRAIN;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic [CNT_W-1:0] rd_ptr_ext_s;
  logic [CNT_W-1:0] count_m1_s;
  logic             full_s;
  logic             wr_en_s;
  logic             rd_valid_s;
  logic             rd_last_s;
  logic             xfer_s;
  logic [REC_W-1:0] mem_rdata_s;

  tv_buffer #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata ({dut_in, dut_out}),
    .raddr (rd_ptr_r),
    .rdata (mem_rdata_s)
  );

  // Write qualification and read-side handshake decode.
  always_comb begin
    full_s       = (count_r == DEPTH_C);
    wr_en_s      = (state_r == S_RECORD) && sample_en && !full_s;
    rd_ptr_ext_s = CNT_W'(rd_ptr_r);
    count_m1_s   = count_r - CNT_W'(1);
    rd_valid_s   = (state_r == S_DRAIN) && (rd_ptr_ext_s < count_r);
    rd_last_s    = rd_valid_s && (rd_ptr_ext_s == count_m1_s);
    xfer_s       = rd_valid_s && rd.rd_ready;
  end

  // Stream outputs; data is forced to zero whenever no record is offered.
  always_comb begin
    rd.rd_valid = rd_valid_s;
    rd.rd_last  = rd_last_s;
    if (rd_valid_s) begin
      rd.rd_data = mem_rdata_s;
    end else begin
      rd.rd_data = '0;
    end
  end

  // Next-state logic. Filling the last slot ends recording in the same
  // cycle as the write; DRAIN leaves as soon as the final record is taken,
  // or immediately when nothing was captured.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_RECORD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RECORD: begin
        if (stop || full_s || (wr_en_s && (count_r == DEPTH_M1_C))) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_RECORD;
        end
      end
      S_DRAIN: begin
        if (!rd_valid_s || (xfer_s && rd_last_s)) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointers, record count and sticky overflow; a start clears the run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
          end
        end
        S_RECORD: begin
          if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            count_r  <= count_r + CNT_W'(1);
          end
          if (sample_en && full_s) begin
            overflow_r <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (xfer_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
          end
          if (sample_en) begin
            overflow_r <= 1'b1;
          end
        end
        default: begin
          wr_ptr_r <= '0;
          rd_ptr_r <= '0;
        end
      endcase
    end
  end

`ifdef TV_RECORDER_CHECK_EN
  logic [15:0] err_count_r;

  // Response-mismatch counter, live only while recording.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_r <= 16'd0;
    end else if ((state_r == S_IDLE) && start) begin
      err_count_r <= 16'd0;
    end else if ((state_r == S_RECORD) && sample_en && (dut_out != exp_out)) begin
      err_count_r <= sat_inc16(err_count_r);
    end
  end

  // Error count output.
  always_comb begin
    err_count = err_count_r;
  end
`endif

  // Status outputs.
  always_comb begin
    busy     = (state_r != S_IDLE);
    count    = count_r;
    overflow = overflow_r;
  end

endmodule

// File: tb/tb_tv_recorder.sv
// -----------------------------------------------------------------------------
// tb_tv_recorder
// Self-checking bench for tv_recorder (IN_W=3, OUT_W=1, DEPTH=16). A queue
// holds the records that should come out of each run; overflow, count and
// (with TV_RECORDER_CHECK_EN) err_count are predicted from the capture rules.
// -----------------------------------------------------------------------------
module tb_tv_recorder;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic       sample_en;
  logic [2:0] dut_in;
  logic [0:0] dut_out;
  logic       busy;
  logic [4:0] count;
  logic       overflow;
`ifdef TV_RECORDER_CHECK_EN
  logic [0:0]  exp_out;
  logic [15:0] err_count;
`endif

  tv_recorder_if #(.REC_W(4)) rd_if ();

  tv_recorder #(
    .IN_W  (3),
    .OUT_W (1),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .sample_en (sample_en),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
`ifdef TV_RECORDER_CHECK_EN
    .exp_out   (exp_out),
    .err_count (err_count),
`endif
    .rd        (rd_if),
    .busy      (busy),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int         n_checks;
  int         n_errs;
  logic [3:0] exp_q [$];
  int         m_cnt;
  bit         m_ovf;
  int         m_err;
  int         last_drain_len;
  logic [3:0] fixed_tab [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full capture/drain run. The first fixed_n record cycles use fixed_tab
  // with sample_en=1; later cycles sample with probability p_samp percent.
  // stop is raised on record cycle stop_at (negative = never). During the
  // drain, sample_en is held for drain_samps cycles. rdy_mode: 0 always
  // ready, 1 random, 2 repeating 1,0,0,1.
  task automatic run(input int p_samp, input int stop_at, input int drain_samps,
                     input int rdy_mode, input int fixed_n);
    int  i;
    int  idx;
    int  n;
    bit  rec;
    bit  done;
    bit  valid_e;
    bit  rdy;
    bit  stalled;
    logic [3:0] held;
    logic [3:0] rec_v;
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_err = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rec", 32'(busy), 32'd1);
    check("count_clr", 32'(count), 32'd0);
    check("ovf_clr", 32'(overflow), 32'd0);
`ifdef TV_RECORDER_CHECK_EN
    check("err_clr", 32'(err_count), 32'd0);
`endif
    rec = 1'b1;
    i = 0;
    while (rec) begin
      if (i < fixed_n) begin
        sample_en = 1'b1;
        rec_v = fixed_tab[i];
      end else begin
        sample_en = ($urandom_range(99) < p_samp);
        rec_v = 4'($urandom);
      end
      {dut_in, dut_out} = rec_v;
      stop  = (i == stop_at);
      start = 1'($urandom_range(1));
`ifdef TV_RECORDER_CHECK_EN
      exp_out = ($urandom_range(1) == 1) ? dut_out : ~dut_out;
      if (sample_en && (exp_out != dut_out)) m_err++;
`endif
      if (sample_en) begin
        if (m_cnt < DEPTH) begin
          exp_q.push_back(rec_v);
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (stop || (m_cnt == DEPTH)) rec = 1'b0;
      @(posedge clk); #1;
      i++;
      check("count_rec", 32'(count), 32'(m_cnt));
      if (rec && (i >= 100)) begin
        check("record_timeout", 32'd0, 32'd1);
        rec = 1'b0;
      end
    end
    start = 1'b0;
    idx = 0;
    n = 0;
    done = 1'b0;
    stalled = 1'b0;
    held = 4'd0;
    while (!done) begin
      valid_e = (idx < m_cnt);
      check("busy_drain", 32'(busy), 32'd1);
      check("rd_valid", 32'(rd_if.rd_valid), 32'(valid_e));
      if (valid_e) begin
        check("rd_data", 32'(rd_if.rd_data), 32'(exp_q[idx]));
        check("rd_last", 32'(rd_if.rd_last), 32'(idx == m_cnt - 1));
        if (stalled) check("rd_stable", 32'(rd_if.rd_data), 32'(held));
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(1));
        default: rdy = ((n % 4) == 0) || ((n % 4) == 3);
      endcase
      rd_if.rd_ready = rdy;
      sample_en = (n < drain_samps);
      {dut_in, dut_out} = 4'($urandom);
      stop = 1'($urandom_range(1));
      if (sample_en) m_ovf = 1'b1;
      stalled = valid_e && !rdy;
      held = rd_if.rd_data;
      if (!valid_e || (rdy && (idx == m_cnt - 1))) done = 1'b1;
      if (valid_e && rdy) idx++;
      @(posedge clk); #1;
      n++;
      if (!done && (n > 300)) begin
        check("drain_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    last_drain_len = n;
    sample_en = 1'b0;
    stop = 1'b0;
    rd_if.rd_ready = 1'b0;
    check("busy_idle", 32'(busy), 32'd0);
    check("rd_valid_idle", 32'(rd_if.rd_valid), 32'd0);
    check("count_hold", 32'(count), 32'(m_cnt));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef TV_RECORDER_CHECK_EN
    check("err_count", 32'(err_count), 32'(m_err));
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errs = 0;
    fixed_tab[0] = 4'b0001;
    fixed_tab[1] = 4'b0100;
    fixed_tab[2] = 4'b1110;
    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    sample_en = 1'b0;
    dut_in = 3'd0;
    dut_out = 1'b0;
    rd_if.rd_ready = 1'b0;
`ifdef TV_RECORDER_CHECK_EN
    exp_out = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("rst_last", 32'(rd_if.rd_last), 32'd0);
    check("rst_data", 32'(rd_if.rd_data), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Three known records, stop on the following cycle, sink always ready.
    run(0, 3, 0, 0, 3);
    check("known_count", 32'(count), 32'd3);

    // Twenty back-to-back samples: 16 stored, the rest overflow in DRAIN.
    run(100, -1, 4, 0, 0);
    check("full_count", 32'(count), 32'd16);
    check("full_ovf", 32'(overflow), 32'd1);

    // Backpressure with rd_ready pattern 1,0,0,1.
    run(70, 10, 0, 2, 0);

    // Immediate stop, nothing captured: one DRAIN cycle, no valid.
    run(0, 0, 0, 0, 0);
    check("empty_drain_len", 32'(last_drain_len), 32'd1);

    // Reset asserted mid-DRAIN clears everything asynchronously.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sample_en = 1'b1;
    repeat (3) begin
      {dut_in, dut_out} = 4'($urandom);
      @(posedge clk); #1;
    end
    sample_en = 1'b0;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    check("pre_rst_valid", 32'(rd_if.rd_valid), 32'd1);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Randomised runs with random backpressure and random stop points.
    for (int r = 0; r < 10; r++) begin
      run(int'($urandom_range(100)), int'($urandom_range(24)) - 2,
          int'($urandom_range(3)), 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
